mul_seq_n: RTL

- Parametrised sequential shift-add multiplier: next generation of the combinational N-bit multiplier.
- Trades area for latency: one partial product per clock, WIDTH cycles per operation.
- start/busy/done handshake; result is held in a register until the next operation completes.
- Used wherever a wide product is needed without a full combinational array, e.g. datapath scaling and accumulator feeds.

---
 rtl/mul_seq_n_if.sv | 13 +
 rtl/mul_seq_n.sv | 68 ++++++
 2 files changed

// File: rtl/mul_seq_n_if.sv
// mul_seq_n_if: start/busy/done handshake and operand/product bus of the sequential multiplier
interface mul_seq_n_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] y;
  modport master (output start, a, b, input busy, done, y);
  modport slave  (input start, a, b, output busy, done, y);
endinterface

// File: rtl/mul_seq_n.sv
// mul_seq_n: shift-add multiplier, one partial product per clock, WIDTH clocks per product; define SIGNED_MODE_EN for two's-complement operands
module mul_seq_n #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic         clk,
  input logic         rst_n,
  mul_seq_n_if.slave  bus
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t             state, state_nx;
  logic [2*WIDTH-1:0] mcd, acc, acc_sum, y_fin, y_q;
  logic [WIDTH-1:0]   mlr, a_abs, b_abs;
  logic [CNT_W-1:0]   cnt;
  logic               done_q, last, take;
`ifdef SIGNED_MODE_EN
  logic               sgn;
  assign a_abs = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_abs = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign y_fin = sgn ? -acc_sum : acc_sum;
  // sign of the product, captured alongside the magnitudes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sgn <= 1'b0;
    else if (take) sgn <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
  assign a_abs = bus.a;
  assign b_abs = bus.b;
  assign y_fin = acc_sum;
`endif
  assign bus.busy = state == CALC;
  assign bus.done = done_q;
  assign bus.y    = y_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state, acceptance and the partial-product sum of the current iteration
  always_comb begin
    last     = cnt == CNT_W'(WIDTH - 1);
    take     = state == IDLE && bus.start;
    acc_sum  = acc + (mlr[0] ? mcd : '0);
    state_nx = state == IDLE ? (bus.start ? CALC : IDLE) : (last ? IDLE : CALC);
  end
  // operand capture, shift-add iteration and final product write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcd    <= '0;
      mlr    <= '0;
      acc    <= '0;
      cnt    <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == CALC && last;
      if (take) begin
        mcd <= {{WIDTH{1'b0}}, a_abs};
        mlr <= b_abs;
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_sum;
        mcd <= mcd << 1;
        mlr <= mlr >> 1;
        cnt <= cnt + CNT_W'(1);
        if (last) y_q <= y_fin;
      end
    end
endmodule
